// File: rtl/jk_updown_counter.sv
// jk_updown_counter: modulo-N up/down counter built from JK flip-flops.
// Each stage's J/K drive is computed from the count and the controls.
module jk_flip_flop (
   input  logic clk,
   input  logic j,
   input  logic k,
   output logic q
);
   logic r_q;
   always_ff @(posedge clk)
      r_q <= (j & k) ? ~r_q : j ? 1'b1 : k ? 1'b0 : r_q;
   assign q = r_q;
endmodule

module jk_updown_counter #(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             ovf
);
   localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);
   logic [WIDTH-1:0] w_q, w_ld, w_step, w_j, w_k;
   logic             w_max, w_zero;
   logic             r_ovf;
   assign w_max  = w_q == MAXV;
   assign w_zero = w_q == '0;
   assign w_ld   = (load_val > MAXV) ? MAXV : load_val;
   assign w_step = up ? (w_max ? '0 : w_q + 1'b1) : (w_zero ? MAXV : w_q - 1'b1);
   assign tc     = ~reset & ~load & en & ((up & w_max) | (~up & w_zero));
   always_comb begin
      w_j = '0;
      w_k = '0;
      if (reset) begin
         w_k = '1;
      end else if (load) begin
         w_j = w_ld;
         w_k = ~w_ld;
      end else if (en) begin
         w_j = w_step & ~w_q;
         w_k = ~w_step & w_q;
      end
   end
   for (genvar i = 0; i < WIDTH; i++) begin : g_stage
      jk_flip_flop u_ff (.clk(clk), .j(w_j[i]), .k(w_k[i]), .q(w_q[i]));
   end
   always_ff @(posedge clk)
      r_ovf <= (reset | load) ? 1'b0 : (tc ? 1'b1 : r_ovf);
   assign count = w_q;
   assign ovf   = r_ovf;
endmodule

// File: tb/tb_jk_updown_counter.sv
// tb_jk_updown_counter: directed and random checks of the mod-10 JK counter
// against an integer reference model.
module tb_jk_updown_counter;
   logic       clk = 1'b0;
   logic       reset, en, up, load;
   logic [3:0] load_val, count;
   logic       tc, ovf;
   int         checks = 0;
   int         failures = 0;
   int         m_cnt = 0;
   bit         m_ovf = 1'b0;

   jk_updown_counter #(.WIDTH(4), .MODULUS(10)) dut (
      .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
      .load_val(load_val), .count(count), .tc(tc), .ovf(ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic bit model_tc(bit r, bit l, bit e, bit u);
      return !r && !l && e && ((u && m_cnt == 9) || (!u && m_cnt == 0));
   endfunction

   task automatic model_edge(bit r, bit l, bit e, bit u, int lv);
      if (r) begin
         m_cnt = 0; m_ovf = 0;
      end else if (l) begin
         m_cnt = (lv > 9) ? 9 : lv; m_ovf = 0;
      end else if (e) begin
         if (u) begin
            if (m_cnt == 9) begin m_cnt = 0; m_ovf = 1; end else m_cnt++;
         end else begin
            if (m_cnt == 0) begin m_cnt = 9; m_ovf = 1; end else m_cnt--;
         end
      end
   endtask

   task automatic step(input bit r, input bit l, input bit e, input bit u, input int lv, input string tag);
      reset = r; load = l; en = e; up = u; load_val = 4'(lv);
      #1;
      chk({tag, "_tc"}, 32'(tc), 32'(model_tc(r, l, e, u)));
      @(posedge clk);
      model_edge(r, l, e, u, lv);
      #1;
      chk({tag, "_count"}, 32'(count), 32'(m_cnt));
      chk({tag, "_ovf"}, 32'(ovf), 32'(m_ovf));
      @(negedge clk);
   endtask

   initial begin
      reset = 1; load = 0; en = 0; up = 1; load_val = 0;
      step(1, 0, 0, 1, 0, "reset0");
      for (int n = 0; n < 12; n++) step(0, 0, 1, 1, 0, "up_run");
      step(1, 0, 0, 1, 0, "reset1");
      step(0, 0, 1, 0, 0, "down_wrap");
      step(0, 0, 1, 0, 0, "down_step");
      step(0, 1, 0, 1, 13, "load_clamp");
      step(0, 0, 1, 1, 0, "wrap_after_load");
      step(0, 1, 1, 1, 5, "load_and_en");
      for (int n = 0; n < 3; n++) step(0, 0, 0, 1, 0, "hold");
      step(0, 1, 0, 1, 9, "load9");
      step(0, 0, 1, 1, 0, "wrap_set_ovf");
      step(0, 1, 0, 1, 7, "load7");
      step(0, 0, 1, 1, 0, "to8");
      step(0, 0, 1, 0, 0, "to7");
      step(1, 1, 1, 1, 3, "reset_wins");
      step(0, 1, 0, 1, 9, "reload9");
      step(0, 0, 1, 1, 0, "wrap_again");
      step(0, 1, 1, 0, 15, "load_clamp_en");
      reset = 0; load = 0; en = 1; up = 1;
      #1;
      chk("toggle_tc_up", 32'(tc), 32'(model_tc(0, 0, 1, 1)));
      up = 0;
      #1;
      chk("toggle_tc_down", 32'(tc), 32'(model_tc(0, 0, 1, 0)));
      @(posedge clk);
      model_edge(0, 0, 1, 0, 0);
      #1;
      chk("toggle_count", 32'(count), 32'(m_cnt));
      chk("toggle_ovf", 32'(ovf), 32'(m_ovf));
      @(negedge clk);
      for (int n = 0; n < 400; n++)
         step($urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0,
              $urandom_range(0, 3) != 0, 1'($urandom), int'($urandom_range(0, 15)), "rand");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
